mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store.
// Data accesses have fixed priority. A starvation counter forces a fetch
// grant after MAX_WAIT consecutive denied fetch cycles, unless dm_lock is held.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              Reset,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // data memory port
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic              dm_lock,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    // RAM port
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    logic             if_rvalid_q;
    logic             dm_rvalid_q;
    logic             starved;

    assign starved = (wait_cnt == WAIT_MAX);

    // Grant selection: lock beats starvation, starvation beats data priority.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (Reset) begin
            if_gnt = 1'b0;
            dm_gnt = 1'b0;
        end else if (dm_req && dm_lock) begin
            dm_gnt = 1'b1;
        end else if (if_req && starved) begin
            if_gnt = 1'b1;
        end else if (dm_req) begin
            dm_gnt = 1'b1;
        end else if (if_req) begin
            if_gnt = 1'b1;
        end
    end

    // RAM drive: data port when it wins, otherwise a harmless fetch-address read.
    always_comb begin
        ram_addr  = if_addr;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (dm_gnt) begin
            ram_addr  = dm_addr;
            ram_wdata = dm_wdata;
            ram_we    = dm_we;
        end
    end

    // Response capture and starvation counter.
    always_ff @(posedge clk) begin
        if (Reset) begin
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            wait_cnt    <= '0;
        end else begin
            if_rvalid_q <= if_gnt;
            dm_rvalid_q <= dm_gnt && !dm_we;
            if (if_gnt) begin
                if_rdata <= ram_rdata;
            end
            if (dm_gnt && !dm_we) begin
                dm_rdata <= ram_rdata;
            end
            if (!if_req || if_gnt) begin
                wait_cnt <= '0;
            end else if (!starved) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // A response due in a cycle where Reset is asserted is dropped.
    assign if_rvalid = if_rvalid_q && !Reset;
    assign dm_rvalid = dm_rvalid_q && !Reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural RAM.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              Reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic              dm_lock;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(3)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_lock   (dm_lock),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with combinational read.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[5] = 32'hDEAD_BEEF;

        // Reset with both requesters active.
        Reset = 1'b1; if_req = 1'b1; if_addr = 10'd5;
        dm_req = 1'b1; dm_we = 1'b1; dm_lock = 1'b0; dm_addr = 10'd9; dm_wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_if_gnt",    32'(if_gnt), 32'd0);
            chk("rst_dm_gnt",    32'(dm_gnt), 32'd0);
            chk("rst_ram_we",    32'(ram_we), 32'd0);
            chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
            chk("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
            chk("rst_if_rdata",  if_rdata, 32'd0);
            chk("rst_dm_rdata",  dm_rdata, 32'd0);
            chk("rst_wait_cnt",  32'(dut.wait_cnt), 32'd0);
        end

        // Fetch only.
        Reset = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        #1;
        chk("fetch_gnt",      32'(if_gnt), 32'd1);
        chk("fetch_dm_gnt",   32'(dm_gnt), 32'd0);
        chk("fetch_ram_addr", 32'(ram_addr), 32'd5);
        chk("fetch_ram_we",   32'(ram_we), 32'd0);
        step();
        if_req = 1'b0;
        #1;
        chk("fetch_rvalid",    32'(if_rvalid), 32'd1);
        chk("fetch_rdata",     if_rdata, 32'hDEAD_BEEF);
        chk("fetch_dm_rvalid", 32'(dm_rvalid), 32'd0);

        // Store then load.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd9; dm_wdata = 32'h1234_5678;
        #1;
        chk("st_dm_gnt",    32'(dm_gnt), 32'd1);
        chk("st_ram_we",    32'(ram_we), 32'd1);
        chk("st_ram_addr",  32'(ram_addr), 32'd9);
        chk("st_ram_wdata", ram_wdata, 32'h1234_5678);
        chk("st_if_rvalid_drop", 32'(if_rvalid), 32'd1);
        step();
        dm_we = 1'b0; dm_wdata = 32'h0;
        #1;
        chk("st_dm_rvalid", 32'(dm_rvalid), 32'd0);
        chk("st_if_rvalid_pulse", 32'(if_rvalid), 32'd0);
        chk("ld_dm_gnt",    32'(dm_gnt), 32'd1);
        chk("ld_ram_we",    32'(ram_we), 32'd0);
        step();
        dm_req = 1'b0;
        #1;
        chk("ld_dm_rvalid", 32'(dm_rvalid), 32'd1);
        chk("ld_dm_rdata",  dm_rdata, 32'h1234_5678);
        chk("ld_if_rvalid", 32'(if_rvalid), 32'd0);
        step();
        chk("ld_rvalid_pulse", 32'(dm_rvalid), 32'd0);
        chk("ld_rdata_hold",   dm_rdata, 32'h1234_5678);
        chk("if_rdata_hold",   if_rdata, 32'hDEAD_BEEF);

        // Starvation: continuous requests give a 3:1 dm:if pattern.
        if_req = 1'b1; if_addr = 10'd5; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd9;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("starve_if_gnt_%0d", i), 32'(if_gnt), ((i % 4) == 3) ? 32'd1 : 32'd0);
            chk($sformatf("starve_dm_gnt_%0d", i), 32'(dm_gnt), ((i % 4) == 3) ? 32'd0 : 32'd1);
            step();
        end

        // Lock holds fetch off; fetch wins the first cycle after it drops.
        dm_lock = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("lock_if_gnt_%0d", i), 32'(if_gnt), 32'd0);
            chk($sformatf("lock_dm_gnt_%0d", i), 32'(dm_gnt), 32'd1);
            step();
        end
        chk("lock_wait_sat", 32'(dut.wait_cnt), 32'd3);
        dm_lock = 1'b0;
        #1;
        chk("unlock_if_gnt", 32'(if_gnt), 32'd1);
        chk("unlock_dm_gnt", 32'(dm_gnt), 32'd0);
        step();
        if_req = 1'b0; dm_req = 1'b0;
        #1;
        chk("unlock_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("unlock_wait_clr",  32'(dut.wait_cnt), 32'd0);
        step();

        // Reset asserted the cycle after a fetch grant drops the response.
        if_req = 1'b1; if_addr = 10'd5;
        #1;
        chk("rmid_if_gnt", 32'(if_gnt), 32'd1);
        step();
        Reset = 1'b1; if_req = 1'b0;
        #1;
        chk("rmid_rvalid_n1", 32'(if_rvalid), 32'd0);
        chk("rmid_ram_we",    32'(ram_we), 32'd0);
        step();
        Reset = 1'b0;
        #1;
        chk("rmid_rvalid_n2", 32'(if_rvalid), 32'd0);
        chk("rmid_rdata_clr", if_rdata, 32'd0);
        chk("rmid_wait_cnt",  32'(dut.wait_cnt), 32'd0);
        step();
        chk("rmid_rvalid_n3", 32'(if_rvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
